// File: rtl/ram_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_master
// Description : Burst initiator for single_port_ram. Write beats arrive on a
//               valid/ready stream, read beats leave through a 2-entry FIFO.
//               Optional macro BURST_ABORT_EN adds abort / done_aborted.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_burst_master #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [AW-1:0]         cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  ram_enable,
  output logic                  ram_we,
  output logic [AW-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [DATA_WIDTH-1:0] ram_write_mask,
  output logic                  ram_write_protect,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_busy,
  output logic                  done
`ifdef BURST_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  done_aborted
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  logic [AW-1:0]         r_cur_addr;
  logic [AW:0]           r_beats_left;
  logic [RD_LATENCY:0]   r_pipe;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_head;
  logic [1:0]            r_count;
  logic                  r_ram_enable;
  logic                  r_ram_we;
  logic [AW-1:0]         r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data_in;
  logic                  r_done;
  logic                  r_done_pend;
`ifdef BURST_ABORT_EN
  logic                  r_aborted;
  logic                  r_done_aborted;
`endif

  logic                  w_abort;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_wr_hs;
  logic                  w_rd_issue;
  logic                  w_last;
  logic [AW-1:0]         w_next_addr;
  logic [2:0]            w_inflight;
  logic [2:0]            w_occ;
  logic [2:0]            w_occ_net;

`ifdef BURST_ABORT_EN
  assign w_abort      = abort;
  assign done_aborted = r_done_aborted;
`else
  assign w_abort      = 1'b0;
`endif

  always_comb begin
    w_inflight = '0;
    for (int k = 0; k <= RD_LATENCY; k++) begin
      w_inflight = w_inflight + {2'b00, r_pipe[k]};
    end
  end

  assign rd_valid  = (r_count != 2'd0);
  assign rd_data   = r_buf[r_head];
  assign w_pop     = rd_valid && rd_ready;
  assign w_push    = r_pipe[RD_LATENCY];
  assign w_occ     = {1'b0, r_count} + w_inflight;
  // A pop this cycle frees a slot before any newly issued beat can land.
  assign w_occ_net = w_occ - {2'b00, w_pop};

  assign cmd_ready   = (r_state == ST_IDLE);
  assign wr_ready    = (r_state == ST_WRITE) && !ram_busy && !w_abort;
  assign w_wr_hs     = wr_valid && wr_ready;
  assign w_rd_issue  = (r_state == ST_READ) && !ram_busy && !w_abort && (w_occ_net < 3'd2);
  assign w_last      = (r_beats_left == {{AW{1'b0}}, 1'b1});
  assign w_next_addr = (r_cur_addr == AW'(DEPTH - 1)) ? '0 : r_cur_addr + 1'b1;

  assign ram_enable        = r_ram_enable;
  assign ram_we            = r_ram_we;
  assign ram_addr          = r_ram_addr;
  assign ram_data_in       = r_ram_data_in;
  assign ram_write_mask    = '1;
  assign ram_write_protect = 1'b0;
  assign done              = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cur_addr    <= '0;
      r_beats_left  <= '0;
      r_pipe        <= '0;
      r_buf[0]      <= '0;
      r_buf[1]      <= '0;
      r_head        <= 1'b0;
      r_count       <= 2'd0;
      r_ram_enable  <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
      r_done        <= 1'b0;
      r_done_pend   <= 1'b0;
`ifdef BURST_ABORT_EN
      r_aborted      <= 1'b0;
      r_done_aborted <= 1'b0;
`endif
    end else begin
      r_ram_enable <= 1'b0;
      r_ram_we     <= 1'b0;
      r_done       <= r_done_pend;
      r_done_pend  <= 1'b0;
      r_pipe       <= {r_pipe[RD_LATENCY-1:0], w_rd_issue};
`ifdef BURST_ABORT_EN
      r_done_aborted <= r_done_pend && r_aborted;
      if (r_done_pend) r_aborted <= 1'b0;
`endif

      // Read FIFO: the slot after the last valid entry receives the landing beat.
      if (w_push) r_buf[r_head ^ r_count[0]] <= ram_data_out;
      if (w_pop) r_head <= ~r_head;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_cur_addr   <= cmd_addr;
            r_beats_left <= {1'b0, cmd_len} + {{AW{1'b0}}, 1'b1};
            r_state      <= cmd_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (w_abort) begin
            r_state     <= ST_IDLE;
            r_done_pend <= 1'b1;
`ifdef BURST_ABORT_EN
            r_aborted   <= 1'b1;
`endif
          end else if (w_wr_hs) begin
            r_ram_enable  <= 1'b1;
            r_ram_we      <= 1'b1;
            r_ram_addr    <= r_cur_addr;
            r_ram_data_in <= wr_data;
            r_cur_addr    <= w_next_addr;
            r_beats_left  <= r_beats_left - 1'b1;
            if (w_last) begin
              r_state     <= ST_IDLE;
              r_done_pend <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_abort) begin
            r_state   <= ST_DRAIN;
`ifdef BURST_ABORT_EN
            r_aborted <= 1'b1;
`endif
          end else if (w_rd_issue) begin
            r_ram_enable <= 1'b1;
            r_ram_addr   <= r_cur_addr;
            r_cur_addr   <= w_next_addr;
            r_beats_left <= r_beats_left - 1'b1;
            if (w_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((w_inflight == 3'd0) && (r_count == 2'd0)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
`ifdef BURST_ABORT_EN
            r_done_aborted <= r_aborted;
            r_aborted      <= 1'b0;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_burst_master
// Description : Directed bench for ram_burst_master with a latency-1 RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_burst_master;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr, cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, rd_ready;
  logic       ram_enable, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_data_in, ram_write_mask, ram_data_out;
  logic       ram_write_protect, ram_busy, done;
`ifdef BURST_ABORT_EN
  logic       abort, done_aborted;
`endif

  ram_burst_master #(.DATA_WIDTH(8), .DEPTH(16), .RD_LATENCY(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_addr          (cmd_addr),
    .cmd_len           (cmd_len),
    .wr_data           (wr_data),
    .wr_valid          (wr_valid),
    .wr_ready          (wr_ready),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .ram_enable        (ram_enable),
    .ram_we            (ram_we),
    .ram_addr          (ram_addr),
    .ram_data_in       (ram_data_in),
    .ram_write_mask    (ram_write_mask),
    .ram_write_protect (ram_write_protect),
    .ram_data_out      (ram_data_out),
    .ram_busy          (ram_busy),
    .done              (done)
`ifdef BURST_ABORT_EN
    ,
    .abort             (abort),
    .done_aborted      (done_aborted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model, one cycle read latency.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_we && !ram_write_protect)
        mem[ram_addr] <= (mem[ram_addr] & ~ram_write_mask) | (ram_data_in & ram_write_mask);
      else if (!ram_we)
        ram_data_out <= mem[ram_addr];
    end
  end

  // Passive recorder of RAM issues, accepted read beats and done pulses.
  bit         iss_we   [$];
  int         iss_addr [$];
  logic [7:0] iss_data [$];
  logic [7:0] rx_q     [$];
  int         done_cnt = 0;
  int         dab_cnt  = 0;
  always @(negedge clk) begin
    if (ram_enable === 1'b1) begin
      iss_we.push_back(ram_we);
      iss_addr.push_back(int'(ram_addr));
      iss_data.push_back(ram_data_in);
    end
    if (rd_valid === 1'b1 && rd_ready === 1'b1) rx_q.push_back(rd_data);
    if (done === 1'b1) done_cnt++;
`ifdef BURST_ABORT_EN
    if (done === 1'b1 && done_aborted === 1'b1) dab_cnt++;
`endif
  end

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] wdat [16];
  logic [7:0] rexp [16];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_reads(input int base);
    int n = 0;
    for (int k = base; k < iss_we.size(); k++) if (!iss_we[k]) n++;
    return n;
  endfunction

  task automatic start_cmd(input bit wr, input int addr, input int len);
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = wr;
    cmd_addr = 4'(addr); cmd_len = 4'(len);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int k = 0;
    while (done_cnt == base && k < 100) begin tick(); k++; end
    repeat (3) tick();
    chk(tag, 32'(done_cnt - base), 1);
  endtask

  task automatic write_burst(input int addr, input int len, input int busy_at, input int busy_n);
    int  i = 0, cyc = 0, ib = iss_addr.size(), db = done_cnt;
    bit  hs, busy;
    start_cmd(1'b1, addr, len);
    while (i <= len && cyc < 100) begin
      busy = (cyc >= busy_at) && (cyc < busy_at + busy_n);
      ram_busy = busy; wr_data = wdat[i]; wr_valid = 1'b1;
      #1;
      hs = wr_ready;
      if (busy) chk("wr_ready_busy", 32'(wr_ready), 0);
      tick();
      if (busy) chk("enable_after_busy", 32'(ram_enable), 0);
      if (hs) i++;
      cyc++;
    end
    wr_valid = 1'b0; ram_busy = 1'b0;
    chk("wr_no_timeout", 32'(cyc < 100), 1);
    wait_done("wr_done_once", db);
    chk("wr_issue_count", 32'(iss_addr.size() - ib), 32'(len + 1));
    for (int k = 0; k <= len && ib + k < iss_addr.size(); k++) begin
      chk("wr_we", 32'(iss_we[ib+k]), 1);
      chk("wr_addr", 32'(iss_addr[ib+k]), 32'((addr + k) % 16));
      chk("wr_data", 32'(iss_data[ib+k]), 32'(wdat[k]));
    end
  endtask

  task automatic collect(input int rxb, input int db, input int n);
    int cyc = 0;
    rd_ready = 1'b1;
    while ((rx_q.size() - rxb < n || done_cnt == db) && cyc < 300) begin tick(); cyc++; end
    repeat (3) tick();
    chk("rd_no_timeout", 32'(cyc < 300), 1);
    chk("rd_beat_count", 32'(rx_q.size() - rxb), 32'(n));
    chk("rd_done_once", 32'(done_cnt - db), 1);
    for (int k = 0; k < n && rxb + k < rx_q.size(); k++)
      chk("rd_data_order", 32'(rx_q[rxb+k]), 32'(rexp[k]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ib, rxb, db;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0; ram_busy = 1'b0;
`ifdef BURST_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_enable", 32'(ram_enable), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_data_in", 32'(ram_data_in), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;
    tick();

    // Fill the whole memory in one DEPTH-beat burst.
    for (int k = 0; k < 16; k++) wdat[k] = 8'(8'h40 + k);
    write_burst(0, 15, 99, 0);

    // Single-beat write, checked cycle by cycle.
    chk("t1_cmd_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd5; cmd_len = 4'd0;
    wr_valid = 1'b1; wr_data = 8'hAA;
    tick();
    cmd_valid = 1'b0;
    chk("t1_cmd_ready_busy", 32'(cmd_ready), 0);
    chk("t1_wr_ready", 32'(wr_ready), 1);
    chk("t1_accept_no_issue", 32'(ram_enable), 0);
    tick();
    wr_valid = 1'b0;
    chk("t1_enable", 32'(ram_enable), 1);
    chk("t1_we", 32'(ram_we), 1);
    chk("t1_addr", 32'(ram_addr), 5);
    chk("t1_data", 32'(ram_data_in), 32'h AA);
    chk("t1_mask", 32'(ram_write_mask), 32'h FF);
    chk("t1_protect", 32'(ram_write_protect), 0);
    chk("t1_done_early", 32'(done), 0);
    tick();
    chk("t1_enable_off", 32'(ram_enable), 0);
    chk("t1_done", 32'(done), 1);
    tick();
    chk("t1_done_pulse", 32'(done), 0);

    // Wrapping write across the top of memory.
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
    write_burst(14, 3, 99, 0);

    // Write with ram_busy high for three cycles mid-burst.
    for (int k = 0; k < 6; k++) wdat[k] = 8'(8'h61 + k);
    write_burst(8, 5, 2, 3);

    // Preload 0..4 with FF, then read them back with rd_ready high.
    for (int k = 0; k < 5; k++) begin wdat[k] = 8'hFF; rexp[k] = 8'hFF; end
    write_burst(0, 4, 99, 0);
    rxb = rx_q.size(); db = done_cnt; ib = iss_we.size();
    rd_ready = 1'b1;
    start_cmd(1'b0, 0, 4);
    collect(rxb, db, 5);
    chk("t3_reads_issued", 32'(count_reads(ib)), 5);

    // Read 8 beats with the consumer stalled for 10 cycles.
    rexp[0] = 8'hFF; rexp[1] = 8'hAA; rexp[2] = 8'h46; rexp[3] = 8'h47;
    rexp[4] = 8'h61; rexp[5] = 8'h62; rexp[6] = 8'h63; rexp[7] = 8'h64;
    rxb = rx_q.size(); db = done_cnt; ib = iss_we.size();
    rd_ready = 1'b0;
    start_cmd(1'b0, 4, 7);
    repeat (5) tick();
    chk("t4_hold_rd_data_a", 32'(rd_data), 32'h FF);
    repeat (5) tick();
    chk("t4_hold_rd_valid", 32'(rd_valid), 1);
    chk("t4_hold_rd_data_b", 32'(rd_data), 32'h FF);
    chk("t4_hold_reads", 32'(count_reads(ib)), 2);
    collect(rxb, db, 8);

    // Reset in the middle of a read with a full buffer.
    rxb = rx_q.size(); db = done_cnt; ib = iss_we.size();
    rd_ready = 1'b0;
    start_cmd(1'b0, 0, 7);
    repeat (8) tick();
    chk("t6_buffered", 32'(rd_valid), 1);
    chk("t6_reads", 32'(count_reads(ib)), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rd_valid", 32'(rd_valid), 0);
    chk("t6_cmd_ready", 32'(cmd_ready), 1);
    chk("t6_done", 32'(done), 0);
    rd_ready = 1'b1;
    repeat (6) tick();
    chk("t6_no_done", 32'(done_cnt - db), 0);
    chk("t6_no_beats", 32'(rx_q.size() - rxb), 0);
    wdat[0] = 8'h5A; wdat[1] = 8'hA5;
    write_burst(2, 1, 99, 0);

`ifdef BURST_ABORT_EN
    // Abort a 6-beat read once two beats have been taken.
    begin
      int cyc = 0;
      rxb = rx_q.size(); db = done_cnt;
      rd_ready = 1'b1;
      start_cmd(1'b0, 0, 5);
      while (rx_q.size() - rxb < 2 && cyc < 50) begin tick(); cyc++; end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      cyc = 0;
      while (done_cnt == db && cyc < 50) begin tick(); cyc++; end
      repeat (3) tick();
      chk("ab_done_once", 32'(done_cnt - db), 1);
      chk("ab_done_aborted", 32'(dab_cnt), 1);
      chk("ab_beats_le4", 32'((rx_q.size() - rxb) <= 4), 1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
